// File: rtl/wd_service_master_pkg.sv
// wd_service_master_pkg: shared watchdog FSM encoding, bus defaults and period helper.
package wd_service_master_pkg;
    typedef enum logic [3:0] {
        IDLE, UNLK_CFG, WR_CFG, UNLK_INIT, WR_INIT, WAIT, UNLK_SVC, WR_SVC, RSTWAIT
    } state_t;
    localparam logic [7:0] WD_KEY       = 8'h5A;
    localparam logic [1:0] WD_ADDR_CFG  = 2'b00;
    localparam logic [1:0] WD_ADDR_SVC  = 2'b01;
    localparam logic [1:0] WD_ADDR_INIT = 2'b11;
    localparam logic [7:0] WD_SVC_DATA  = 8'h01;
    function automatic logic [15:0] eff_period(input logic [15:0] p);
        return (p == 16'd0) ? 16'd1 : p;
    endfunction
endpackage

// File: rtl/wd_service_master_if.sv
// wd_service_master_if: control inputs and watchdog bus/status outputs of the service master.
interface wd_service_master_if;
    logic       START;
    logic       HALT;
    logic [7:0] CFG_DATA;
    logic [15:0] SVC_PERIOD;
    logic       RSTOUT;
    logic [1:0] ABUS;
    logic [7:0] DBUS;
    logic       BUSY;
    logic       FAULT;
    logic [7:0] SVC_CNT;
    modport master (
        input  START, HALT, CFG_DATA, SVC_PERIOD, RSTOUT,
        output ABUS, DBUS, BUSY, FAULT, SVC_CNT
    );
    modport slave (
        output START, HALT, CFG_DATA, SVC_PERIOD, RSTOUT,
        input  ABUS, DBUS, BUSY, FAULT, SVC_CNT
    );
endinterface

// File: rtl/wd_service_master_svc_timer.sv
// svc_timer: service period counter; clears, counts while enabled, holds at expiry under hold.
module svc_timer
    import wd_service_master_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        hold,
    input  logic [15:0] period,
    output logic        expired
);
    logic [15:0] cnt_q, cnt_d;
    always_comb begin
        expired = cnt_q == eff_period(period) - 16'd1;
        cnt_d = clr ? 16'd0 : (en && !(hold && expired)) ? cnt_q + 16'd1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 16'd0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/wd_service_master.sv
// wd_service_master: configures a watchdog with keyed two-phase writes, then services it periodically.
module wd_service_master
    import wd_service_master_pkg::*;
#(
    parameter logic [7:0] KEY       = WD_KEY,
    parameter logic [1:0] ADDR_CFG  = WD_ADDR_CFG,
    parameter logic [1:0] ADDR_SVC  = WD_ADDR_SVC,
    parameter logic [1:0] ADDR_INIT = WD_ADDR_INIT,
    parameter logic [7:0] SVC_DATA  = WD_SVC_DATA
) (
    input logic CLK,
    input logic RST,
    wd_service_master_if.master wd
);
    state_t state_q, state_d;
    logic [1:0] abus_q, abus_d;
    logic [7:0] dbus_q, dbus_d, cfg_q, cfg_d, cnt_q, cnt_d;
    logic [15:0] per_q, per_d;
    logic fault_q, fault_d, abort, accept, expired;
    svc_timer u_timer (
        .clk(CLK), .rst(RST),
        .clr(state_q == WR_INIT || state_q == WR_SVC),
        .en(state_q == WAIT), .hold(wd.HALT),
        .period(per_q), .expired(expired)
    );
    // bus is decoded from the current state, so it trails the state by one cycle
    always_comb begin
        abort = (state_q != IDLE) && wd.RSTOUT;
        accept = (state_q == IDLE) && wd.START;
        state_d = state_q;
        abus_d = 2'b00;
        dbus_d = 8'h00;
        case (state_q)
            IDLE:      state_d = wd.START ? UNLK_CFG : IDLE;
            UNLK_CFG:  begin state_d = WR_CFG; dbus_d = KEY; end
            WR_CFG:    begin state_d = UNLK_INIT; abus_d = ADDR_CFG; dbus_d = cfg_q; end
            UNLK_INIT: begin state_d = WR_INIT; dbus_d = KEY; end
            WR_INIT:   begin state_d = WAIT; abus_d = ADDR_INIT; dbus_d = SVC_DATA; end
            WAIT:      state_d = (expired && !wd.HALT) ? UNLK_SVC : WAIT;
            UNLK_SVC:  begin state_d = WR_SVC; dbus_d = KEY; end
            WR_SVC:    begin state_d = WAIT; abus_d = ADDR_SVC; dbus_d = SVC_DATA; end
            default:   state_d = IDLE;
        endcase
        // a watchdog reset request kills any pending phase, so no orphan DATA follows a KEY
        if (abort) begin
            state_d = RSTWAIT;
            abus_d = 2'b00;
            dbus_d = 8'h00;
        end
        fault_d = abort || (fault_q && !accept);
        cfg_d = accept ? wd.CFG_DATA : cfg_q;
        per_d = accept ? wd.SVC_PERIOD : per_q;
        cnt_d = (state_q == WR_SVC && !abort) ? cnt_q + 8'd1 : cnt_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            abus_q <= 2'b00;
            dbus_q <= 8'h00;
            fault_q <= 1'b0;
            cnt_q <= 8'h00;
            cfg_q <= 8'h00;
            per_q <= 16'd0;
        end else begin
            state_q <= state_d;
            abus_q <= abus_d;
            dbus_q <= dbus_d;
            fault_q <= fault_d;
            cnt_q <= cnt_d;
            cfg_q <= cfg_d;
            per_q <= per_d;
        end
    end
    assign wd.ABUS = abus_q;
    assign wd.DBUS = dbus_q;
    assign wd.BUSY = state_q != IDLE;
    assign wd.FAULT = fault_q;
    assign wd.SVC_CNT = cnt_q;
endmodule

// File: tb/tb_wd_service_master.sv
// tb_wd_service_master: directed stimulus, bus-beat queue model checked every cycle, literal spot checks.
module tb_wd_service_master;
    import wd_service_master_pkg::*;
    logic clk = 1'b0;
    logic rst;
    wd_service_master_if wd();
    wd_service_master dut (.CLK(clk), .RST(rst), .wd(wd.master));
    always #5 clk = ~clk;

    typedef struct packed {logic [1:0] a; logic [7:0] d; logic svc; logic opens_wait;} beat_t;
    beat_t pend[$];
    logic m_busy = 1'b0, m_rw = 1'b0, m_fault = 1'b0;
    logic [7:0] m_cnt = 8'h00, m_d = 8'h00;
    logic [1:0] m_a = 2'b00;
    int m_waited = 0, m_p = 1;
    int vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_is(input string name, input logic [1:0] a, input logic [7:0] d);
        chk(name, {22'd0, wd.ABUS, wd.DBUS}, {22'd0, a, d});
    endtask

    // bus beats are queued per write; wait length counts cycles spent after each data beat
    task automatic model_step();
        beat_t b;
        if (rst) begin
            m_busy = 0; m_rw = 0; m_fault = 0; m_cnt = 0; m_a = 0; m_d = 0; m_waited = 0;
            pend.delete();
        end else if (!m_busy) begin
            m_a = 0; m_d = 0;
            if (wd.START) begin
                m_busy = 1; m_fault = 0;
                m_p = (wd.SVC_PERIOD == 16'd0) ? 1 : int'(wd.SVC_PERIOD);
                pend.push_back(beat_t'{2'b00, 8'h5A, 1'b0, 1'b0});
                pend.push_back(beat_t'{2'b00, wd.CFG_DATA, 1'b0, 1'b0});
                pend.push_back(beat_t'{2'b00, 8'h5A, 1'b0, 1'b0});
                pend.push_back(beat_t'{2'b11, 8'h01, 1'b0, 1'b1});
            end
        end else if (m_rw) begin
            m_a = 0; m_d = 0;
            if (!wd.RSTOUT) begin m_busy = 0; m_rw = 0; end
        end else if (wd.RSTOUT) begin
            m_rw = 1; m_fault = 1; m_a = 0; m_d = 0;
            pend.delete();
        end else if (pend.size() > 0) begin
            b = pend.pop_front();
            m_a = b.a; m_d = b.d;
            if (b.svc) m_cnt++;
            if (b.opens_wait) m_waited = 1;
        end else begin
            m_a = 0; m_d = 0;
            if (m_waited >= m_p && !wd.HALT) begin
                pend.push_back(beat_t'{2'b00, 8'h5A, 1'b0, 1'b0});
                pend.push_back(beat_t'{2'b01, 8'h01, 1'b1, 1'b1});
            end else m_waited++;
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
        chk("cycle", {12'd0, wd.ABUS, wd.DBUS, wd.BUSY, wd.FAULT, wd.SVC_CNT},
            {12'd0, m_a, m_d, m_busy, m_fault, m_cnt});
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        logic [9:0] cfg_seq [4];
        cfg_seq = '{{2'b00, 8'h5A}, {2'b00, 8'h3C}, {2'b00, 8'h5A}, {2'b11, 8'h01}};
        rst = 1; wd.START = 1; wd.CFG_DATA = 8'h3C; wd.SVC_PERIOD = 16'd10; wd.HALT = 0; wd.RSTOUT = 0;
        cyc(1);
        chk("reset_with_start", {12'd0, wd.ABUS, wd.DBUS, wd.BUSY, wd.FAULT, wd.SVC_CNT}, 32'd0);
        wd.START = 0;
        cyc(1);
        rst = 0;
        cyc(1);
        chk("idle_busy", {31'd0, wd.BUSY}, 32'd0);
        wd.START = 1;
        cyc(1);
        wd.START = 0;
        chk("start_busy", {31'd0, wd.BUSY}, 32'd1);
        bus_is("start_bus", 2'b00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("cfg_seq", {22'd0, wd.ABUS, wd.DBUS}, {22'd0, cfg_seq[i]});
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            bus_is("wait_idle", 2'b00, 8'h00);
        end
        cyc(1);
        bus_is("svc1_key", 2'b00, 8'h5A);
        cyc(1);
        bus_is("svc1_data", 2'b01, 8'h01);
        chk("svc1_cnt", {24'd0, wd.SVC_CNT}, 32'd1);
        wd.HALT = 1;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            bus_is("halt_idle", 2'b00, 8'h00);
        end
        chk("halt_cnt", {24'd0, wd.SVC_CNT}, 32'd1);
        wd.HALT = 0;
        cyc(1);
        bus_is("unhalt_1", 2'b00, 8'h00);
        cyc(1);
        bus_is("unhalt_key", 2'b00, 8'h5A);
        cyc(1);
        chk("unhalt_cnt", {24'd0, wd.SVC_CNT}, 32'd2);
        cyc(11);
        bus_is("pre_abort_key", 2'b00, 8'h5A);
        wd.RSTOUT = 1;
        cyc(1);
        bus_is("abort_bus", 2'b00, 8'h00);
        chk("abort_fault", {31'd0, wd.FAULT}, 32'd1);
        chk("abort_state", {28'd0, dut.state_q}, {28'd0, RSTWAIT});
        chk("abort_cnt", {24'd0, wd.SVC_CNT}, 32'd2);
        cyc(2);
        chk("rstwait_busy", {31'd0, wd.BUSY}, 32'd1);
        wd.RSTOUT = 0;
        cyc(1);
        chk("post_rw_busy", {31'd0, wd.BUSY}, 32'd0);
        chk("post_rw_fault", {31'd0, wd.FAULT}, 32'd1);
        wd.RSTOUT = 1;
        cyc(2);
        chk("idle_rstout", {30'd0, wd.BUSY, wd.FAULT}, 32'd1);
        wd.RSTOUT = 0;
        rst = 1;
        cyc(1);
        rst = 0;
        wd.START = 1; wd.CFG_DATA = 8'hA5; wd.SVC_PERIOD = 16'd0;
        cyc(1);
        wd.START = 0;
        chk("restart_fault", {31'd0, wd.FAULT}, 32'd0);
        cyc(4);
        bus_is("p0_init", 2'b11, 8'h01);
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            if (k % 3 == 1) bus_is("p0_gap", 2'b00, 8'h00);
            else if (k % 3 == 2) bus_is("p0_key", 2'b00, 8'h5A);
            else bus_is("p0_data", 2'b01, 8'h01);
        end
        chk("p0_cnt4", {24'd0, wd.SVC_CNT}, 32'd4);
        cyc(753);
        chk("cnt_255", {24'd0, wd.SVC_CNT}, 32'd255);
        cyc(3);
        chk("cnt_wrap", {24'd0, wd.SVC_CNT}, 32'd0);
        bus_is("wrap_data", 2'b01, 8'h01);
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wd_service_master.md
WD_SERVICE_MASTER -- requirements
Module: wd_service_master

Interface
REQ-001 SHALL have parameter KEY, 8'h5A: unlock byte driven on DBUS one cycle before every register write.
REQ-002 SHALL have parameter ADDR_CFG, 2'b00: watchdog configuration register address.
REQ-003 SHALL have parameter ADDR_SVC, 2'b01: watchdog service register address.
REQ-004 SHALL have parameter ADDR_INIT, 2'b11: watchdog init register address.
REQ-005 SHALL have parameter SVC_DATA, 8'h01: data byte written at ADDR_SVC and ADDR_INIT.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have port CLK, input, 1: sole clock; all logic on rising edge.
REQ-008 SHALL have port RST, input, 1: reset.
REQ-009 SHALL have port START, input, 1: one-cycle pulse that begins the configure/service sequence.
REQ-010 SHALL have port HALT, input, 1: level; while high, no service writes are issued (fault injection).
REQ-011 SHALL have port CFG_DATA, input, 8: byte written at ADDR_CFG, sampled on START.
REQ-012 SHALL have port SVC_PERIOD, input, 16: cycles between service writes, sampled on START.
REQ-013 SHALL have port RSTOUT, input, 1: reset request returned by the watchdog.
REQ-014 SHALL have port ABUS, output, 2: watchdog address bus.
REQ-015 SHALL have port DBUS, output, 8: watchdog data bus.
REQ-016 SHALL have port BUSY, output, 1: high in every state except IDLE.
REQ-017 SHALL have port FAULT, output, 1: sticky flag; watchdog reset was observed.
REQ-018 SHALL have port SVC_CNT, output, 8: count of completed service writes, wraps 255->0.

Function
REQ-019 SHALL issue every write as two consecutive cycles: KEY phase (ABUS=2'b00, DBUS=KEY), then DATA phase (ABUS=addr, DBUS=data).
REQ-020 SHALL drive ABUS=2'b00 and DBUS=8'h00 in every cycle that is not a KEY or DATA phase.
REQ-021 SHALL register ABUS and DBUS, so a state's values appear on the cycle after entering it.
REQ-022 SHALL implement FSM states IDLE, UNLK_CFG, WR_CFG, UNLK_INIT, WR_INIT, WAIT, UNLK_SVC, WR_SVC, RSTWAIT.
REQ-023 SHALL move IDLE->UNLK_CFG on START, latching CFG_DATA and SVC_PERIOD and clearing FAULT.
REQ-024 SHALL follow the fixed sequence UNLK_CFG->WR_CFG->UNLK_INIT->WR_INIT->WAIT, one cycle per state.
REQ-025 SHALL have WR_INIT clear the 16-bit period counter.
REQ-026 SHALL, in WAIT, increment the counter each cycle and go to UNLK_SVC when counter equals latched period minus 1, with period 0 treated as 1.
REQ-027 SHALL, in WAIT with HALT high, hold the counter at its expiry value and not leave WAIT.
REQ-028 SHALL, after HALT falls at an expired count, leave WAIT on the next cycle.
REQ-029 SHALL follow UNLK_SVC->WR_SVC->WAIT, with WR_SVC clearing the counter and incrementing SVC_CNT.
REQ-030 SHALL ignore START outside IDLE.
REQ-031 SHALL, when RSTOUT is high in any state other than IDLE, set FAULT and enter RSTWAIT on the next cycle.
REQ-032 SHALL let RSTOUT take priority over all other transitions, including mid-write; an interrupted KEY phase is never followed by its DATA phase.
REQ-033 SHALL stay in RSTWAIT while RSTOUT is high, and go to IDLE on the first cycle RSTOUT is low.
REQ-034 SHALL ignore RSTOUT in IDLE, leaving FAULT unchanged.
REQ-035 SHALL clear FAULT only on RST or on an accepted START.

Reset
REQ-036 SHALL, on RST high at a clock edge, set state=IDLE, ABUS=2'b00, DBUS=8'h00, BUSY=0, FAULT=0, SVC_CNT=0, counter=0, and clear both latches.
REQ-037 SHALL let RST override START and RSTOUT in the same cycle.

Structure
REQ-038 SHALL define the FSM state encoding and the KEY/ADDR_* defaults in a shared watchdog package, where they are also used by the watchdog configuration decoder.
REQ-039 SHALL implement the period counter as sub-module svc_timer (clear, enable, hold, expiry compare).

Verification
REQ-040 SHALL test reset then START with CFG_DATA=8'h3C and SVC_PERIOD=10 -> bus shows (00,5A),(00,3C),(00,5A),(11,01), then idle; the first (00,5A),(01,01) appears 10 cycles after WR_INIT.
REQ-041 SHALL test SVC_PERIOD=0 -> a service write is issued every 3 cycles (1 wait + 2 bus cycles), and SVC_CNT reaches 4 after 12 cycles in the service loop.
REQ-042 SHALL test HALT held 50 cycles with SVC_PERIOD=10 -> no bus writes and SVC_CNT frozen; the KEY phase appears 2 cycles after HALT falls.
REQ-043 SHALL test RSTOUT pulsed during a KEY phase -> the next bus cycle is idle (00,00), FAULT=1, state RSTWAIT; after RSTOUT falls, BUSY=0 and FAULT stays 1.
REQ-044 SHALL test 256 service writes -> SVC_CNT wraps to 8'h00.
REQ-045 SHALL test START asserted in the same cycle as RST -> all outputs remain at reset values.
